// File: rtl/pattern_seq_detector_pkg.sv
// Shared defaults, mode encoding and width helper for the pattern sequence detector.
package pattern_seq_detector_pkg;

    localparam int         PAT_MAX_LEN_C = 8;
    localparam int         CNT_W_C       = 8;
    localparam logic [7:0] DEF_PAT_C     = 8'b0010_1011;
    localparam int         DEF_LEN_C     = 6;
    localparam bit         DEF_OVL_C     = 1'b1;

    // After a full match, overlapping mode keeps the longest border of the
    // pattern as the new prefix; non-overlapping mode starts from scratch.
    typedef enum logic {
        MODE_NOVL = 1'b0,
        MODE_OVL  = 1'b1
    } ovl_mode_e;

    // Width able to hold any length from 0 up to max_len inclusive.
    function automatic int len_w_f(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pattern_seq_detector_prefix_matcher.sv
// Combinational matcher: compares the bit history (newest bit at index 0)
// against the programmed pattern and finds the longest proper prefix that
// the history currently ends with. Only bits actually sampled (vld_i) count.
module prefix_matcher
    import pattern_seq_detector_pkg::*;
#(
    parameter int  PAT_MAX_LEN = PAT_MAX_LEN_C,
    localparam int LEN_W       = len_w_f(PAT_MAX_LEN)
) (
    input  logic [PAT_MAX_LEN-1:0] hist_i,
    input  logic [LEN_W-1:0]       vld_i,
    input  logic [PAT_MAX_LEN-1:0] pat_i,
    input  logic [LEN_W-1:0]       len_i,
    output logic                   hit_o,
    output logic [LEN_W-1:0]       pfx_o
);

    // Mask selecting the k least significant bits.
    function automatic logic [PAT_MAX_LEN-1:0] low_mask_f(input int k);
        logic [PAT_MAX_LEN-1:0] m;
        for (int i = 0; i < PAT_MAX_LEN; i++) begin
            m[i] = (i < k);
        end
        return m;
    endfunction

    logic [PAT_MAX_LEN-1:0] len_mask_s;

    // Full-length compare plus ascending search for the longest matching prefix.
    // The first k pattern bits are pat[len-1 -: k], so they line up with the
    // k newest history bits once the pattern is shifted right by len-k.
    always_comb begin
        len_mask_s = low_mask_f(int'(len_i));
        hit_o      = (vld_i >= len_i) &&
                     ((hist_i & len_mask_s) == (pat_i & len_mask_s));
        pfx_o      = '0;
        for (int k = 1; k < PAT_MAX_LEN; k++) begin
            pfx_o = ((k < int'(len_i)) && (k <= int'(vld_i)) &&
                     ((hist_i & low_mask_f(k)) ==
                      ((pat_i >> (int'(len_i) - k)) & low_mask_f(k))))
                    ? LEN_W'(k) : pfx_o;
        end
    end

endmodule

// File: rtl/pattern_seq_detector.sv
// Programmable serial pattern detector: keeps a bit history and a count of
// valid bits, reports a one-cycle registered match flag, the current matched
// prefix length and a saturating match counter.
module pattern_seq_detector
    import pattern_seq_detector_pkg::*;
#(
    parameter int                     PAT_MAX_LEN = PAT_MAX_LEN_C,
    parameter int                     CNT_W       = CNT_W_C,
    parameter logic [PAT_MAX_LEN-1:0] DEF_PAT     = PAT_MAX_LEN'(DEF_PAT_C),
    parameter int                     DEF_LEN     = DEF_LEN_C,
    parameter bit                     DEF_OVL     = DEF_OVL_C,
    localparam int                    LEN_W       = len_w_f(PAT_MAX_LEN)
) (
    input  logic                   clk_o,
    input  logic                   reset,
    input  logic                   x,
    input  logic                   en,
    input  logic                   load,
    input  logic [PAT_MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]       len_in,
    input  logic                   ovl_in,
    output logic                   z,
    output logic [LEN_W-1:0]       state_q,
    output logic [CNT_W-1:0]       match_cnt
);

    // The history only needs PAT_MAX_LEN-1 old bits; the live x completes it.
    logic [PAT_MAX_LEN-1:0] pat_q, pat_d, hist_sh_s;
    logic [PAT_MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]       len_q, len_d, vld_q, vld_d, vld_inc_s;
    logic [LEN_W-1:0]       state_d, pfx_s, len_clamp_s;
    ovl_mode_e              ovl_q, ovl_d;
    logic                   z_q, z_d, hit_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign hist_sh_s = {hist_q, x};
    assign vld_inc_s = (vld_q == LEN_W'(PAT_MAX_LEN)) ? vld_q : vld_q + LEN_W'(1);
    assign z         = z_q;
    assign match_cnt = cnt_q;

    prefix_matcher #(
        .PAT_MAX_LEN (PAT_MAX_LEN)
    ) u_matcher (
        .hist_i (hist_sh_s),
        .vld_i  (vld_inc_s),
        .pat_i  (pat_q),
        .len_i  (len_q),
        .hit_o  (hit_s),
        .pfx_o  (pfx_s)
    );

    // Clamp the requested length into 1..PAT_MAX_LEN before latching.
    always_comb begin
        if (len_in == '0) begin
            len_clamp_s = LEN_W'(1);
        end else if (len_in > LEN_W'(PAT_MAX_LEN)) begin
            len_clamp_s = LEN_W'(PAT_MAX_LEN);
        end else begin
            len_clamp_s = len_in;
        end
    end

    // Next-state selection: load wins, then a sampled bit, otherwise hold.
    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        vld_d   = vld_q;
        state_d = state_q;
        z_d     = 1'b0;
        cnt_d   = cnt_q;
        if (load) begin
            pat_d   = pat_in;
            len_d   = len_clamp_s;
            ovl_d   = ovl_mode_e'(ovl_in);
            hist_d  = '0;
            vld_d   = '0;
            state_d = '0;
            cnt_d   = '0;
        end else if (en) begin
            if (hit_s) begin
                z_d   = 1'b1;
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                if (ovl_q == MODE_OVL) begin
                    hist_d  = hist_sh_s[PAT_MAX_LEN-2:0];
                    vld_d   = vld_inc_s;
                    state_d = pfx_s;
                end else begin
                    hist_d  = '0;
                    vld_d   = '0;
                    state_d = '0;
                end
            end else begin
                hist_d  = hist_sh_s[PAT_MAX_LEN-2:0];
                vld_d   = vld_inc_s;
                state_d = pfx_s;
            end
        end else begin
            hist_d  = hist_q;
            vld_d   = vld_q;
            state_d = state_q;
        end
    end

    // State registers; reset restores the default pattern and clears progress.
    always_ff @(posedge clk_o or posedge reset) begin
        if (reset) begin
            pat_q   <= DEF_PAT;
            len_q   <= LEN_W'(DEF_LEN);
            ovl_q   <= ovl_mode_e'(DEF_OVL);
            hist_q  <= '0;
            vld_q   <= '0;
            state_q <= '0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            vld_q   <= vld_d;
            state_q <= state_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
